// File: rtl/rv32_mem_access.sv
// RV32 memory stage: data-bus load/store with byte-lane steering and load extension,
// branch resolution, and the writeback-stage pipeline register.
module rv32_mem_access (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        mem_read_en_in,
    input  logic        mem_write_en_in,
    input  logic [1:0]  mem_width_in,
    input  logic        mem_zero_extend_in,
    input  logic [1:0]  branch_op_in,
    input  logic [4:0]  rd_in,
    input  logic        rd_writeback_in,
    input  logic [31:0] result_in,
    input  logic [31:0] rs2_value_in,
    input  logic [31:0] branch_pc_in,
    output logic [31:0] data_address_out,
    output logic        data_read_out,
    output logic        data_write_out,
    output logic [3:0]  data_write_mask_out,
    output logic [31:0] data_write_value_out,
    input  logic [31:0] data_read_value_in,
    input  logic        data_ready_in,
    output logic        busy_out,
    output logic        misaligned_out,
    output logic        branch_taken_out,
    output logic [31:0] branch_pc_out,
    output logic [4:0]  rd_out,
    output logic        rd_writeback_out,
    output logic [31:0] rd_value_out
);

    typedef enum logic { ISSUE, DONE } state_t;

    localparam logic [1:0] WIDTH_BYTE = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;

    localparam logic [1:0] BR_NEVER    = 2'd0;
    localparam logic [1:0] BR_ZERO     = 2'd1;
    localparam logic [1:0] BR_NON_ZERO = 2'd2;

    state_t      state, state_next;
    logic [1:0]  addr_low;
    logic        misaligned;
    logic        mem_access;
    logic        update;
    logic [31:0] captured_data;
    logic [31:0] load_raw;
    logic [31:0] load_shifted;
    logic [31:0] load_value;

    assign addr_low         = result_in[1:0];
    assign data_address_out = {result_in[31:2], 2'b00};
    assign branch_pc_out    = branch_pc_in;

    // Width 3 is reserved and behaves like a word access.
    assign misaligned = (mem_width_in == WIDTH_HALF) ? addr_low[0] :
                        (mem_width_in == WIDTH_BYTE) ? 1'b0 : (addr_low != 2'b00);
    assign mem_access = (mem_read_en_in | mem_write_en_in) & ~flush_in;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= ISSUE;
        else          state <= state_next;
    end

    // NOTE: every signal driven here gets a default first so no latch can be inferred.
    always_comb begin
        state_next           = state;
        data_read_out        = 1'b0;
        data_write_out       = 1'b0;
        data_write_mask_out  = 4'b0000;
        data_write_value_out = rs2_value_in;
        branch_taken_out     = 1'b0;

        if (state == ISSUE && !flush_in && !misaligned) begin
            data_read_out  = mem_read_en_in;
            data_write_out = mem_write_en_in;
        end

        case (mem_width_in)
            WIDTH_BYTE: data_write_value_out = {4{rs2_value_in[7:0]}};
            WIDTH_HALF: data_write_value_out = {2{rs2_value_in[15:0]}};
            default:    data_write_value_out = rs2_value_in;
        endcase

        if (data_write_out) begin
            case (mem_width_in)
                WIDTH_BYTE: data_write_mask_out = 4'b0001 << addr_low;
                WIDTH_HALF: data_write_mask_out = addr_low[1] ? 4'b1100 : 4'b0011;
                default:    data_write_mask_out = 4'b1111;
            endcase
        end

        case (state)
            ISSUE: if ((data_read_out | data_write_out) && data_ready_in && stall_in)
                       state_next = DONE;
            DONE:  if (!stall_in) state_next = ISSUE;
            default: state_next = ISSUE;
        endcase

        case (branch_op_in)
            BR_NEVER:    branch_taken_out = 1'b0;
            BR_ZERO:     branch_taken_out = (result_in == 32'd0);
            BR_NON_ZERO: branch_taken_out = (result_in != 32'd0);
            default:     branch_taken_out = 1'b1;
        endcase
        if (flush_in) branch_taken_out = 1'b0;
    end

    assign busy_out = (data_read_out | data_write_out) & ~data_ready_in;
    assign update   = ~stall_in & ~busy_out;

    // Lane extraction uses the captured word once the bus has already answered.
    always_comb begin
        load_raw     = (state == DONE) ? captured_data : data_read_value_in;
        load_shifted = load_raw >> {addr_low, 3'b000};
        case (mem_width_in)
            WIDTH_BYTE: load_value = {{24{~mem_zero_extend_in & load_shifted[7]}}, load_shifted[7:0]};
            WIDTH_HALF: load_value = {{16{~mem_zero_extend_in & load_shifted[15]}}, load_shifted[15:0]};
            default:    load_value = load_raw;
        endcase
    end

    // NOTE: captured_data is a plain data holding register and is deliberately not reset;
    // it is only read in DONE, which is always entered after a capture.
    always_ff @(posedge clk) begin
        if (state == ISSUE && data_read_out && data_ready_in)
            captured_data <= data_read_value_in;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_out           <= 5'd0;
            rd_writeback_out <= 1'b0;
            rd_value_out     <= 32'd0;
            misaligned_out   <= 1'b0;
        end else begin
            misaligned_out <= update & mem_access & misaligned;
            if (update) begin
                rd_out           <= rd_in;
                rd_value_out     <= mem_read_en_in ? load_value : result_in;
                rd_writeback_out <= rd_writeback_in & ~flush_in & ~(mem_access & misaligned);
            end
        end
    end

endmodule
